run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_sequencer.sv | 136 +++++++++++++
 tb/tb_run_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
`default_nettype none
// run_sequencer: steps a processor through a batch of up to four programs, measuring RUN cycles of each.
// Optional watchdog built when RUN_SEQUENCER_TIMEOUT_EN is defined; otherwise Timeout is tied low.
module run_sequencer #(
  parameter int START_CYCLES   = 2,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic [1:0]       ProgLast,
  input  logic             Done,
  output logic             Start,
  output logic [1:0]       ProgSel,
  output logic             Busy,
  output logic             ProgDone,
  output logic [CNT_W-1:0] CycleCount,
  output logic             AllDone,
  output logic             Timeout
);

  localparam int              ACW         = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [ACW-1:0]  ASSERT_LAST = ACW'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [ACW-1:0]   assert_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic [1:0]       prog_last;
  logic             done_ok;
  logic             wd_hit;
  logic             prog_end;
  logic [CNT_W-1:0] wd_report;

  // A Done seen on the very first RUN cycle may be left over from the previous program.
  assign done_ok = (state == RUN) && Done && (run_cnt != '0);

`ifdef RUN_SEQUENCER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_REPORT = CNT_W'(TIMEOUT_CYCLES);

  assign wd_hit    = (state == RUN) && !done_ok && (run_cnt == WD_LAST);
  assign wd_report = WD_REPORT;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Timeout <= 1'b0;
    end else if (state == IDLE && Go) begin
      Timeout <= 1'b0;
    end else if (wd_hit) begin
      Timeout <= 1'b1;
    end
  end
`else
  assign wd_hit    = 1'b0;
  assign wd_report = '0;
  assign Timeout   = 1'b0;
`endif

  assign prog_end = done_ok || wd_hit;
  assign Start    = (state != RUN);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Go) state_next = ASSERT;
      ASSERT:  if (assert_cnt == ASSERT_LAST) state_next = RUN;
      RUN:     if (prog_end) state_next = (ProgSel == prog_last) ? FINISH : ASSERT;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      assert_cnt <= '0;
      run_cnt    <= '0;
      prog_last  <= 2'd0;
      ProgSel    <= 2'd0;
      Busy       <= 1'b0;
      ProgDone   <= 1'b0;
      CycleCount <= '0;
      AllDone    <= 1'b0;
    end else begin
      ProgDone <= prog_end;
      case (state)
        IDLE: begin
          if (Go) begin
            prog_last  <= ProgLast;
            ProgSel    <= 2'd0;
            Busy       <= 1'b1;
            AllDone    <= 1'b0;
            assert_cnt <= '0;
          end
        end
        ASSERT: begin
          assert_cnt <= (assert_cnt == ASSERT_LAST) ? '0 : assert_cnt + ACW'(1);
          run_cnt    <= '0;
          // ProgSel advances only after the ProgDone cycle so the pulse reports the finished index.
          if (ProgDone) ProgSel <= ProgSel + 2'd1;
        end
        RUN: begin
          if (run_cnt != CNT_MAX) run_cnt <= run_cnt + CNT_W'(1);
          if (done_ok) begin
            CycleCount <= run_cnt;
          end else if (wd_hit) begin
            CycleCount <= wd_report;
          end
          if (prog_end && (ProgSel == prog_last)) begin
            Busy    <= 1'b0;
            AllDone <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
// tb_run_sequencer: randomized batches checked against a transaction-level model of the sequencer.
module tb_run_sequencer;

  localparam int START_CYCLES   = 2;
  localparam int CNT_W          = 5;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int CNT_MAX        = (1 << CNT_W) - 1;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             Reset, Go, Done;
  logic [1:0]       ProgLast;
  logic             Start, Busy, ProgDone, AllDone, Timeout;
  logic [1:0]       ProgSel;
  logic [CNT_W-1:0] CycleCount;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  run_sequencer #(
    .START_CYCLES  (START_CYCLES),
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .Clk       (clk),
    .Reset     (Reset),
    .Go        (Go),
    .ProgLast  (ProgLast),
    .Done      (Done),
    .Start     (Start),
    .ProgSel   (ProgSel),
    .Busy      (Busy),
    .ProgDone  (ProgDone),
    .CycleCount(CycleCount),
    .AllDone   (AllDone),
    .Timeout   (Timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_start"},    Start,      1);
    check({tag, "_progsel"},  ProgSel,    0);
    check({tag, "_busy"},     Busy,       0);
    check({tag, "_progdone"}, ProgDone,   0);
    check({tag, "_count"},    CycleCount, 0);
    check({tag, "_alldone"},  AllDone,    0);
    check({tag, "_timeout"},  Timeout,    0);
  endtask

  // Acts as the processor for one program: entered on the first Start-high cycle of that program,
  // raises Done on RUN cycle d (or holds Done high throughout when held), and checks the outcome.
  task automatic run_program(input int p, input int d, input bit held, input bit noise,
                             input int rst_at, input bit tmo_in,
                             output bit tmo_out, output bit was_rst);
    int n, k, q, exp_k, exp_cnt;
    bit seen, hits_wd;
    n = 0; k = 0; seen = 1'b0; was_rst = 1'b0;
    q       = held ? 1 : d;
    hits_wd = WD_ON && (q >= TIMEOUT_CYCLES);
    exp_k   = hits_wd ? TIMEOUT_CYCLES - 1 : q;
    exp_cnt = hits_wd ? TIMEOUT_CYCLES : ((q > CNT_MAX) ? CNT_MAX : q);
    tmo_out = tmo_in | hits_wd;

    while (Start === 1'b1 && n < 4 * START_CYCLES + 4) begin
      Done     = held ? 1'b1 : 1'($urandom_range(0, 1));
      Go       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      ProgLast = 2'($urandom_range(0, 3));
      tick();
      n++;
    end
    check("assert_len", n, START_CYCLES);
    check("run_sel", ProgSel, p);

    while (!seen && k < 100) begin
      if (k == rst_at) begin
        Reset = 1'b1; Go = 1'b0; Done = 1'b0;
        tick();
        Reset   = 1'b0;
        was_rst = 1'b1;
        return;
      end
      Done     = held ? 1'b1 : (k == d);
      Go       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      ProgLast = 2'($urandom_range(0, 3));
      tick();
      if (ProgDone === 1'b1) seen = 1'b1;
      else k++;
    end
    Go = 1'b0;

    check("pd_seen", seen, (WD_ON || exp_k < 100));
    if (seen) begin
      check("pd_cycle",   k,          exp_k);
      check("pd_sel",     ProgSel,    p);
      check("pd_count",   CycleCount, exp_cnt);
      check("pd_timeout", Timeout,    tmo_out);
    end else begin
      check("hang_busy",    Busy,    1);
      check("hang_timeout", Timeout, 0);
    end
  endtask

  task automatic run_batch(input int last, input bit noise, input int dl[4], input bit hl[4]);
    bit tmo, rst;
    tmo = 1'b0;
    Go = 1'b1; ProgLast = 2'(last); Done = 1'b0;
    tick();
    Go = 1'b0;
    check("go_busy",    Busy,    1);
    check("go_alldone", AllDone, 0);
    check("go_timeout", Timeout, 0);
    check("go_sel",     ProgSel, 0);
    for (int p = 0; p <= last; p++) begin
      run_program(p, dl[p], hl[p], noise, -1, tmo, tmo, rst);
    end
    Done = 1'b0;
    check("fin_busy",    Busy,    0);
    check("fin_alldone", AllDone, 1);
    tick();
    check("idle_start",    Start,    1);
    check("idle_progdone", ProgDone, 0);
    check("idle_alldone",  AllDone,  1);
    check("idle_busy",     Busy,     0);
    check("idle_timeout",  Timeout,  tmo);
    repeat ($urandom_range(0, 3)) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int dl[4];
    bit hl[4];
    bit tmo, rst;

    Reset = 1'b1; Go = 1'b0; Done = 1'b0; ProgLast = 2'd0;
    repeat (3) tick();
    check_reset("por");
    Reset = 1'b0;
    tick();

    dl = '{10, 0, 0, 0}; hl = '{0, 0, 0, 0};
    run_batch(0, 1'b0, dl, hl);

    dl = '{5, 7, 9, 0};
    run_batch(2, 1'b0, dl, hl);

    // Done held high across ASSERT into RUN
    dl = '{3, 3, 0, 0}; hl = '{1, 1, 0, 0};
    run_batch(1, 1'b0, dl, hl);

    // watchdog tie, watchdog limit, counter saturation, sticky Timeout
    dl = '{TIMEOUT_CYCLES - 1, TIMEOUT_CYCLES, 40, 2}; hl = '{0, 0, 0, 0};
    run_batch(3, 1'b0, dl, hl);

    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < 4; i++) begin
        dl[i] = $urandom_range(1, 15);
        hl[i] = ($urandom_range(0, 4) == 0);
      end
      run_batch($urandom_range(0, 3), 1'b1, dl, hl);
    end

    // Reset in the middle of program 1's RUN phase
    Go = 1'b1; ProgLast = 2'd3;
    tick();
    Go = 1'b0;
    run_program(0, 3, 1'b0, 1'b0, -1, 1'b0, tmo, rst);
    run_program(1, 1000, 1'b0, 1'b0, WD_ON ? 10 : 50, tmo, tmo, rst);
    check("rst_taken", rst, 1);
    check_reset("mid_run");

    // Reset during ASSERT
    Go = 1'b1; ProgLast = 2'd2;
    tick();
    Go = 1'b0; Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_reset("mid_assert");

    // Done never arrives
    Go = 1'b1; ProgLast = 2'd0;
    tick();
    Go = 1'b0;
    run_program(0, 1000, 1'b0, 1'b0, -1, 1'b0, tmo, rst);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_reset("after_hang");

    dl = '{4, 6, 0, 0}; hl = '{0, 0, 0, 0};
    run_batch(1, 1'b0, dl, hl);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
